uart8_echo_responder: RTL and testbench

- Responder end of the Uart8 byte link. Consumes completed bytes from a Uart8 rx interface, buffers them in a small FIFO, and sends each one back through the same Uart8 tx interface.
- Drives the txStart/in handshake the way a host does: hold txStart until txBusy rises, then wait for completion.
- Sits between Uart8 and board-level glue; used for loopback bring-up and as the base for command responders.

---
 rtl/uart8_echo_responder_pkg.sv | 16 +
 rtl/uart8_echo_responder_fifo.sv | 51 +++++
 rtl/uart8_echo_responder.sv | 123 ++++++++++++
 tb/tb_uart8_echo_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart8_echo_responder_pkg.sv
// uart8_echo_responder_pkg: shared FSM encoding and ASCII constants for the Uart8 echo responder
package uart8_echo_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_SEND  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    localparam logic [7:0] ASCII_LO    = 8'h61;
    localparam logic [7:0] ASCII_HI    = 8'h7A;
    localparam logic [7:0] UPCASE_MASK = 8'hDF;

endpackage

// File: rtl/uart8_echo_responder_fifo.sv
// uart8_echo_responder_fifo: circular byte FIFO with synchronous flush, head-of-queue read
module uart8_echo_responder_fifo #(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    wdata,
    output logic [7:0]    head,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem_q [2**AW];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;

    // pointer and count update; flush wins over any push/pop
    always_comb begin
        wr_d  = flush ? '0 : wr_q + AW'(push);
        rd_d  = flush ? '0 : rd_q + AW'(pop);
        cnt_d = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    // pointer and count registers
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // storage write; a full FIFO may still write when a pop frees the head slot
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= wdata;
    end

    assign head  = mem_q[rd_q];
    assign count = cnt_q;
    assign full  = cnt_q[AW];
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/uart8_echo_responder.sv
// uart8_echo_responder: queues Uart8 rx bytes and echoes them via the tx handshake; UART_RESP_UPCASE_EN upcases a..z
module uart8_echo_responder
    import uart8_echo_responder_pkg::*;
#(
    parameter int FIFO_DEPTH_LOG2 = 3,
    parameter int START_TIMEOUT   = 4096,
    parameter int DROP_CNT_W      = 8
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     en,
    input  logic                     rxDone,
    input  logic                     rxErr,
    input  logic [7:0]               rxByte,
    input  logic                     txBusy,
    input  logic                     txDone,
    output logic                     txEn,
    output logic                     txStart,
    output logic [7:0]               txByte,
    output logic [FIFO_DEPTH_LOG2:0] fifoCount,
    output logic                     overflow,
    output logic [DROP_CNT_W-1:0]    dropCount
);

    localparam int TW  = $clog2(START_TIMEOUT + 1);
    localparam int DW1 = DROP_CNT_W + 1;
    localparam logic [TW-1:0] T_LAST = TW'(START_TIMEOUT - 1);

    state_e                state_q, state_d;
    logic                  rx_done_q, tx_done_q, tx_en_q;
    logic                  tx_start_q, tx_start_d;
    logic [7:0]            tx_byte_q, tx_byte_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;
    logic [DW1-1:0]        drop_sum;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  push_evt, rx_drop, push, pop, tmo_drop, full, empty;
    logic [7:0]            head, wdata;

`ifdef UART_RESP_UPCASE_EN
    assign wdata = (rxByte >= ASCII_LO && rxByte <= ASCII_HI) ? (rxByte & UPCASE_MASK) : rxByte;
`else
    assign wdata = rxByte;
`endif

    uart8_echo_responder_fifo #(.AW(FIFO_DEPTH_LOG2)) u_fifo (
        .clk   (clk),
        .rstN  (rstN),
        .flush (~en),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .head  (head),
        .count (fifoCount),
        .full  (full),
        .empty (empty)
    );

    // rx capture, drop accounting (rx drop and start timeout may coincide) with saturation
    always_comb begin
        push_evt   = rxDone & ~rx_done_q & en;
        rx_drop    = push_evt & (rxErr | (full & ~pop));
        push       = push_evt & ~rx_drop;
        overflow_d = overflow_q | (push_evt & ~rxErr & full & ~pop);
        tmo_drop   = en & (state_q == ST_START) & ~txBusy & (tmo_q == T_LAST);
        drop_sum   = {1'b0, drop_q} + DW1'(rx_drop) + DW1'(tmo_drop);
        drop_d     = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
    end

    // next-state logic; a low enable forces IDLE from any state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  state_d = empty ? ST_IDLE : ST_LOAD;
            ST_LOAD:  state_d = ST_START;
            ST_START: state_d = txBusy ? ST_SEND : (tmo_q == T_LAST) ? ST_GAP : ST_START;
            ST_SEND:  state_d = (~txBusy | (txDone & ~tx_done_q)) ? ST_GAP : ST_SEND;
            ST_GAP:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (!en) state_d = ST_IDLE;
    end

    // outputs: pop in LOAD, txStart registered so it drops on the edge txBusy is seen
    always_comb begin
        pop        = (state_q == ST_LOAD);
        tx_start_d = (state_d == ST_START);
        tx_byte_d  = pop ? head : tx_byte_q;
        tmo_d      = (state_q == ST_START && state_d == ST_START) ? tmo_q + 1'b1 : '0;
    end

    // state and output registers
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= ST_IDLE;
            rx_done_q  <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_en_q    <= 1'b0;
            tx_start_q <= 1'b0;
            tx_byte_q  <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            rx_done_q  <= rxDone;
            tx_done_q  <= txDone;
            tx_en_q    <= en;
            tx_start_q <= tx_start_d;
            tx_byte_q  <= tx_byte_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            tmo_q      <= tmo_d;
        end
    end

    assign txEn      = tx_en_q;
    assign txStart   = tx_start_q;
    assign txByte    = tx_byte_q;
    assign overflow  = overflow_q;
    assign dropCount = drop_q;

endmodule

// File: tb/tb_uart8_echo_responder.sv
// tb_uart8_echo_responder: directed vectors plus handshake sequences against a behavioural Uart8 tx peer
module tb_uart8_echo_responder;

    logic       clk = 1'b0;
    logic       rstN, en, rxDone, rxErr, txBusy, txDone;
    logic [7:0] rxByte;
    logic       txEn, txStart, overflow;
    logic [7:0] txByte, dropCount;
    logic [3:0] fifoCount;

    int checks = 0;
    int failures = 0;
    int exp_drop = 0;

    logic       auto_tx = 1'b1;
    logic       hold = 1'b0;
    logic       busy_act = 1'b0;
    int         bcnt = 0;
    logic [7:0] echo_q[$];

`ifdef UART_RESP_UPCASE_EN
    localparam logic [7:0] EXP_61 = 8'h41;
`else
    localparam logic [7:0] EXP_61 = 8'h61;
`endif

    typedef struct {
        logic [7:0] din;
        logic       err;
        logic       echoed;
        logic [7:0] dout;
    } vec_t;

    vec_t vecs[7];

    uart8_echo_responder #(
        .FIFO_DEPTH_LOG2 (3),
        .START_TIMEOUT   (16),
        .DROP_CNT_W      (8)
    ) dut (
        .clk       (clk),
        .rstN      (rstN),
        .en        (en),
        .rxDone    (rxDone),
        .rxErr     (rxErr),
        .rxByte    (rxByte),
        .txBusy    (txBusy),
        .txDone    (txDone),
        .txEn      (txEn),
        .txStart   (txStart),
        .txByte    (txByte),
        .fifoCount (fifoCount),
        .overflow  (overflow),
        .dropCount (dropCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] echo_at(input int i);
        return (i < echo_q.size()) ? {24'b0, echo_q[i]} : 32'hFFFF_FFFF;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic e);
        rxByte = b;
        rxErr  = e;
        rxDone = 1'b1;
        @(negedge clk);
        rxDone = 1'b0;
        rxErr  = 1'b0;
        @(negedge clk);
    endtask

    // behavioural Uart8 transmitter: accepts txStart, stays busy a few cycles (or while held), pulses txDone
    initial begin
        txBusy = 1'b0;
        txDone = 1'b0;
        forever begin
            @(negedge clk);
            if (!busy_act) begin
                txDone = 1'b0;
                if (auto_tx && txStart) begin
                    busy_act = 1'b1;
                    txBusy   = 1'b1;
                    echo_q.push_back(txByte);
                    bcnt     = 4;
                end
            end else if (!hold) begin
                if (bcnt == 0) begin
                    txBusy   = 1'b0;
                    txDone   = 1'b1;
                    busy_act = 1'b0;
                end else begin
                    bcnt--;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int lat, hi;
        vecs[0] = '{8'h8A, 1'b0, 1'b1, 8'h8A};
        vecs[1] = '{8'h00, 1'b0, 1'b1, 8'h00};
        vecs[2] = '{8'hFF, 1'b0, 1'b1, 8'hFF};
        vecs[3] = '{8'h55, 1'b1, 1'b0, 8'h00};
        vecs[4] = '{8'h61, 1'b0, 1'b1, EXP_61};
        vecs[5] = '{8'h7B, 1'b0, 1'b1, 8'h7B};
        vecs[6] = '{8'h5A, 1'b0, 1'b1, 8'h5A};

        rstN = 1'b0; en = 1'b1; rxDone = 1'b0; rxErr = 1'b0; rxByte = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_txEn", txEn, 0);
        chk("rst_txStart", txStart, 0);
        chk("rst_txByte", txByte, 0);
        chk("rst_fifoCount", fifoCount, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_dropCount", dropCount, 0);
        rstN = 1'b1;
        @(negedge clk);
        chk("txEn_follows_en", txEn, 1);

        rxByte = 8'h8A; rxErr = 1'b0; rxDone = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) rxDone = 1'b0;
            if (txStart) lat = k;
        end
        chk("latency_cycles", lat, 3);
        repeat (30) @(negedge clk);
        chk("loop_echo_n", echo_q.size(), 1);
        chk("loop_echo_byte", echo_at(0), 8'h8A);
        chk("loop_txByte", txByte, 8'h8A);
        chk("loop_dropCount", dropCount, 0);

        for (int i = 0; i < 7; i++) begin
            echo_q.delete();
            send_byte(vecs[i].din, vecs[i].err);
            if (vecs[i].err) begin
                exp_drop++;
                chk("vec_err_fifoCount", fifoCount, 0);
            end
            repeat (40) @(negedge clk);
            chk("vec_echo_n", echo_q.size(), vecs[i].echoed ? 1 : 0);
            if (vecs[i].echoed) chk("vec_echo_byte", echo_at(0), vecs[i].dout);
            chk("vec_dropCount", dropCount, exp_drop);
            chk("vec_fifoCount", fifoCount, 0);
        end
        chk("pre_burst_overflow", overflow, 0);

        auto_tx = 1'b0;
        send_byte(8'h33, 1'b0);
        for (int k = 0; k < 20 && !txStart; k++) @(negedge clk);
        hi = 0;
        while (txStart && hi < 40) begin
            hi++;
            @(negedge clk);
        end
        exp_drop++;
        chk("timeout_txStart_cycles", hi, 16);
        chk("timeout_txStart_low", txStart, 0);
        chk("timeout_dropCount", dropCount, exp_drop);
        auto_tx = 1'b1;
        echo_q.delete();
        repeat (3) @(negedge clk);
        send_byte(8'h34, 1'b0);
        repeat (40) @(negedge clk);
        chk("after_timeout_echo_n", echo_q.size(), 1);
        chk("after_timeout_echo", echo_at(0), 8'h34);

        echo_q.delete();
        hold = 1'b1;
        for (int b = 0; b < 10; b++) send_byte(8'(b), 1'b0);
        exp_drop++;
        chk("burst_fifoCount_full", fifoCount, 8);
        chk("burst_overflow", overflow, 1);
        chk("burst_dropCount", dropCount, exp_drop);
        hold = 1'b0;
        repeat (200) @(negedge clk);
        chk("burst_echo_n", echo_q.size(), 9);
        for (int b = 0; b < 9; b++) chk("burst_echo_order", echo_at(b), b);

        echo_q.delete();
        hold = 1'b1;
        send_byte(8'hC0, 1'b0);
        repeat (10) @(negedge clk);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        chk("en_pre_fifoCount", fifoCount, 3);
        en = 1'b0;
        @(negedge clk);
        chk("en_off_fifoCount", fifoCount, 0);
        chk("en_off_txStart", txStart, 0);
        chk("en_off_txEn", txEn, 0);
        chk("en_off_overflow_kept", overflow, 1);
        chk("en_off_dropCount_kept", dropCount, exp_drop);
        hold = 1'b0;
        repeat (20) @(negedge clk);
        echo_q.delete();
        en = 1'b1;
        repeat (2) @(negedge clk);
        send_byte(8'hA5, 1'b0);
        repeat (40) @(negedge clk);
        chk("reen_echo_n", echo_q.size(), 1);
        chk("reen_echo_byte", echo_at(0), 8'hA5);
        chk("reen_fifoCount", fifoCount, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
